hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage RISC-V core.
- Sits beside the forwarding unit and drives the write-enables, bubbles and flushes of the PC, IF/ID, ID/EX and EX/MEM registers.
- Handles three cases forwarding cannot resolve: load-use hazards with configurable load latency, multi-cycle EX operations (mul/div) and taken-branch flushes.
- Small FSM plus a stall counter; outputs are Mealy (current state + current-cycle inputs).

---
 rtl/hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, multi-cycle EX freezes and taken-branch flushes.
// Optional performance counters are compiled in with `define HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 3
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int unsigned PERF_W   = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        IF_ID_rs1,
    input  logic [4:0]        IF_ID_rs2,
    input  logic              IF_ID_use_rs1,
    input  logic              IF_ID_use_rs2,
    input  logic [4:0]        ID_EX_rd,
    input  logic              ID_EX_memread,
    input  logic              ID_EX_multicycle,
    input  logic              ex_done,
    input  logic              branch_taken,
    output logic              pc_write,
    output logic              IF_ID_write,
    output logic              IF_ID_flush,
    output logic              ID_EX_write,
    output logic              ID_EX_bubble,
    output logic              EX_MEM_bubble,
    output logic              stalled
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_flushes
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LU_WAIT = 2'd1,
        EX_WAIT = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             lu_hazard;
    logic             flush_act;

    assign lu_hazard = ID_EX_memread && (ID_EX_rd != 5'd0) &&
                       ((IF_ID_use_rs1 && (IF_ID_rs1 == ID_EX_rd)) ||
                        (IF_ID_use_rs2 && (IF_ID_rs2 == ID_EX_rd)));

    // Next-state and Mealy output decode; reset overrides the outputs last
    always_comb begin
        next_state    = state;
        next_cnt      = cnt;
        flush_act     = 1'b0;
        pc_write      = 1'b1;
        IF_ID_write   = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EX_write   = 1'b1;
        ID_EX_bubble  = 1'b0;
        EX_MEM_bubble = 1'b0;
        stalled       = 1'b0;
        case (state)
            RUN: begin
                if (branch_taken) begin
                    flush_act    = 1'b1;
                    IF_ID_flush  = 1'b1;
                    ID_EX_bubble = 1'b1;
                end else if (ID_EX_multicycle && !ex_done) begin
                    pc_write      = 1'b0;
                    IF_ID_write   = 1'b0;
                    ID_EX_write   = 1'b0;
                    EX_MEM_bubble = 1'b1;
                    stalled       = 1'b1;
                    next_state    = EX_WAIT;
                end else if (lu_hazard) begin
                    pc_write     = 1'b0;
                    IF_ID_write  = 1'b0;
                    ID_EX_bubble = 1'b1;
                    stalled      = 1'b1;
                    if (LOAD_LAT > 1) begin
                        next_cnt   = CNT_W'(LOAD_LAT - 1);
                        next_state = LU_WAIT;
                    end
                end
            end
            LU_WAIT: begin
                pc_write     = 1'b0;
                IF_ID_write  = 1'b0;
                ID_EX_bubble = 1'b1;
                stalled      = 1'b1;
                next_cnt     = (cnt != '0) ? cnt - CNT_W'(1) : '0;
                // cnt==0 can only follow a corrupted state; leave rather than hang
                if (cnt <= CNT_W'(1)) next_state = RUN;
            end
            EX_WAIT: begin
                if (!ex_done) begin
                    pc_write      = 1'b0;
                    IF_ID_write   = 1'b0;
                    ID_EX_write   = 1'b0;
                    EX_MEM_bubble = 1'b1;
                    stalled       = 1'b1;
                end else begin
                    next_state = RUN;
                end
            end
            default: begin
                next_state = RUN;
                next_cnt   = '0;
            end
        endcase
        if (!rst_n) begin
            flush_act     = 1'b0;
            pc_write      = 1'b0;
            IF_ID_write   = 1'b0;
            ID_EX_write   = 1'b0;
            IF_ID_flush   = 1'b1;
            ID_EX_bubble  = 1'b1;
            EX_MEM_bubble = 1'b1;
            stalled       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
            perf_flushes      <= '0;
        end else begin
            if (stalled && !(&perf_stall_cycles))
                perf_stall_cycles <= perf_stall_cycles + PERF_W'(1);
            if (flush_act && !(&perf_flushes))
                perf_flushes <= perf_flushes + PERF_W'(1);
        end
    end
`else
    logic unused_flush_act;
    assign unused_flush_act = flush_act;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with LOAD_LAT=1 and one with LOAD_LAT=3 share stimulus.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, memread, mc, ex_done, branch;

    logic pc1, ifw1, iff1, idw1, idb1, exb1, st1;
    logic pc3, ifw3, iff3, idw3, idb3, exb3, st3;
    logic [6:0] o1, o3;

    int tests_run = 0;
    int tests_failed = 0;

    // Output vector order: pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble, EX_MEM_bubble, stalled
    localparam logic [6:0] DEF = 7'b1101000;
    localparam logic [6:0] BR  = 7'b1111100;
    localparam logic [6:0] LU  = 7'b0001101;
    localparam logic [6:0] MC  = 7'b0000011;
    localparam logic [6:0] RST = 7'b0010110;

    assign o1 = {pc1, ifw1, iff1, idw1, idb1, exb1, st1};
    assign o3 = {pc3, ifw3, iff3, idw3, idb3, exb3, st3};

`ifdef HAZARD_PERF_CNT_EN
    logic [1:0]  ps1, pf1;
    logic [31:0] ps3, pf3;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(
        .LOAD_LAT(1), .CNT_W(3)
`ifdef HAZARD_PERF_CNT_EN
        , .PERF_W(2)
`endif
    ) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .IF_ID_use_rs1(use1), .IF_ID_use_rs2(use2),
        .ID_EX_rd(rd), .ID_EX_memread(memread), .ID_EX_multicycle(mc),
        .ex_done(ex_done), .branch_taken(branch),
        .pc_write(pc1), .IF_ID_write(ifw1), .IF_ID_flush(iff1), .ID_EX_write(idw1),
        .ID_EX_bubble(idb1), .EX_MEM_bubble(exb1), .stalled(st1)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cycles(ps1), .perf_flushes(pf1)
`endif
    );

    hazard_ctrl #(
        .LOAD_LAT(3), .CNT_W(3)
`ifdef HAZARD_PERF_CNT_EN
        , .PERF_W(32)
`endif
    ) u_lat3 (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .IF_ID_use_rs1(use1), .IF_ID_use_rs2(use2),
        .ID_EX_rd(rd), .ID_EX_memread(memread), .ID_EX_multicycle(mc),
        .ex_done(ex_done), .branch_taken(branch),
        .pc_write(pc3), .IF_ID_write(ifw3), .IF_ID_flush(iff3), .ID_EX_write(idw3),
        .ID_EX_bubble(idb3), .EX_MEM_bubble(exb3), .stalled(st3)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cycles(ps3), .perf_flushes(pf3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        use1 = 1'b0; use2 = 1'b0; memread = 1'b0;
        mc = 1'b0; ex_done = 1'b0; branch = 1'b0;
    endtask

    task automatic load_use_rs1(input logic [4:0] r);
        idle();
        memread = 1'b1; rd = r; rs1 = r; use1 = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        #2;
        check("rst_lat1", 32'(o1), 32'(RST));
        check("rst_lat3", 32'(o3), 32'(RST));
        #10 rst_n = 1'b1;
        #1;
        check("post_rst_lat1", 32'(o1), 32'(DEF));
        check("post_rst_lat3", 32'(o3), 32'(DEF));
        cyc();

        // Load-use on rs1: LAT1 stalls once, LAT3 stalls three cycles
        load_use_rs1(5'd5);
        #1;
        check("lu_c0_lat1", 32'(o1), 32'(LU));
        check("lu_c0_lat3", 32'(o3), 32'(LU));
        cyc(); idle(); #1;
        check("lu_c1_lat1", 32'(o1), 32'(DEF));
        check("lu_c1_lat3", 32'(o3), 32'(LU));
        cyc(); #1;
        check("lu_c2_lat3", 32'(o3), 32'(LU));
        cyc(); #1;
        check("lu_c3_lat3", 32'(o3), 32'(DEF));

        // No hazard when rd is x0 or the source is unused
        cyc(); idle();
        memread = 1'b1; rd = 5'd0; rs1 = 5'd0; use1 = 1'b1; #1;
        check("rd0_lat1", 32'(o1), 32'(DEF));
        check("rd0_lat3", 32'(o3), 32'(DEF));
        cyc(); idle();
        memread = 1'b1; rd = 5'd5; rs1 = 5'd5; use1 = 1'b0; #1;
        check("nouse_lat1", 32'(o1), 32'(DEF));
        check("nouse_lat3", 32'(o3), 32'(DEF));

        // Hazard through rs2
        cyc(); idle();
        memread = 1'b1; rd = 5'd7; rs2 = 5'd7; use2 = 1'b1; #1;
        check("rs2_lat1", 32'(o1), 32'(LU));
        check("rs2_lat3", 32'(o3), 32'(LU));
        cyc(); idle();
        cyc(); cyc(); #1;
        check("rs2_done_lat3", 32'(o3), 32'(DEF));

        // Multi-cycle op: four frozen cycles, then result cycle
        for (int i = 0; i < 4; i++) begin
            idle(); mc = 1'b1; #1;
            check($sformatf("mc_wait%0d_lat1", i), 32'(o1), 32'(MC));
            check($sformatf("mc_wait%0d_lat3", i), 32'(o3), 32'(MC));
            cyc();
        end
        idle(); mc = 1'b1; ex_done = 1'b1; #1;
        check("mc_done_lat1", 32'(o1), 32'(DEF));
        check("mc_done_lat3", 32'(o3), 32'(DEF));
        cyc(); idle(); #1;
        check("mc_after_lat1", 32'(o1), 32'(DEF));
        cyc(); idle(); mc = 1'b1; ex_done = 1'b1; #1;
        check("mc_single_lat1", 32'(o1), 32'(DEF));
        check("mc_single_lat3", 32'(o3), 32'(DEF));

        // Branch wins over a simultaneous load-use hazard
        cyc(); load_use_rs1(5'd5); branch = 1'b1; #1;
        check("br_lu_lat1", 32'(o1), 32'(BR));
        check("br_lu_lat3", 32'(o3), 32'(BR));
        cyc(); idle(); #1;
        check("br_after_lat1", 32'(o1), 32'(DEF));
        check("br_after_lat3", 32'(o3), 32'(DEF));

        // Reset while LAT3 sits in LU_WAIT with cnt=2
        cyc(); load_use_rs1(5'd9); #1;
        check("rlu_c0_lat3", 32'(o3), 32'(LU));
        cyc(); idle(); #1;
        check("rlu_c1_lat3", 32'(o3), 32'(LU));
        #2 rst_n = 1'b0;
        #1;
        check("rlu_rst_lat3", 32'(o3), 32'(RST));
        check("rlu_rst_lat1", 32'(o1), 32'(RST));
        cyc(); rst_n = 1'b1; #1;
        check("rlu_rel_lat3", 32'(o3), 32'(DEF));
        cyc(); #1;
        check("rlu_rel2_lat3", 32'(o3), 32'(DEF));

`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall0_lat3", ps3, 32'd0);
        check("perf_flush0_lat3", pf3, 32'd0);
        load_use_rs1(5'd3);
        cyc(); idle(); cyc(); cyc();
        branch = 1'b1; cyc(); idle(); cyc();
        branch = 1'b1; cyc(); idle(); #1;
        check("perf_stall_lat3", ps3, 32'd3);
        check("perf_flush_lat3", pf3, 32'd2);
        check("perf_stall_lat1", 32'(ps1), 32'd1);
        check("perf_flush_lat1", 32'(pf1), 32'd2);
        mc = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        ex_done = 1'b1; cyc(); idle(); #1;
        check("perf_sat_lat1", 32'(ps1), 32'd3);
        check("perf_flush_hold_lat1", 32'(pf1), 32'd2);
        check("perf_stall_mc_lat3", ps3, 32'd8);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
